// File: rtl/rxreq_posq.sv
// rxreq_posq: credit-controlled RXREQ receive FIFO presenting its oldest flit to rxreq_slc
// Ports: clock / reset (async, active-low); rxreqflitv + rxreqflit from the link;
//   rxreqlcrdv link credit grant (registered); pout_valid / pout_ready / rxreq_posq_first_entry_o
//   head handshake (fall-through from storage); posq_count occupancy; err sticky protocol error.
// rxreqflit is the packed reqflit_t image with Opcode at [OPC_LSB +: OPC_W].
// Define RXREQ_POSQ_ERR_CHK_EN to enable the no-credit / overflow checks, flit dropping and err.
module rxreq_posq #(
  parameter int DEPTH   = 8,
  parameter int FLIT_W  = 32,
  parameter int OPC_LSB = 0,
  parameter int OPC_W   = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rxreqflitv,
  input  logic [FLIT_W-1:0]         rxreqflit,
  output logic                      rxreqlcrdv,
  output logic                      pout_valid,
  input  logic                      pout_ready,
  output logic [FLIT_W-1:0]         rxreq_posq_first_entry_o,
  output logic [$clog2(DEPTH):0]    posq_count,
  output logic                      err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, crd_out_q, crd_out_d;
  logic lcrdv_q, lcrdv_d, push_req, push, pop, crd_use;
  // ReqLCrdReturn (Opcode 0) only hands a credit back; it is never stored
  assign push_req = rxreqflitv && (rxreqflit[OPC_LSB +: OPC_W] != '0);
  assign pop      = pout_valid && pout_ready;
`ifdef RXREQ_POSQ_ERR_CHK_EN
  logic err_q, err_d, no_crd, ovf;
  assign no_crd   = rxreqflitv && (crd_out_q == '0);
  assign ovf      = push_req && (count_q == CW'(DEPTH));
  // Offending flits are dropped so count and crd_out saturate instead of wrapping
  assign push     = push_req && !no_crd && !ovf;
  assign crd_use  = rxreqflitv && !no_crd;
  always_comb err_d = err_q || no_crd || ovf;
  always_ff @(posedge clock or negedge reset)
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  assign err = err_q;
`else
  assign push     = push_req;
  assign crd_use  = rxreqflitv;
  assign err      = 1'b0;
`endif
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    crd_out_d = crd_out_q + CW'(lcrdv_q) - CW'(crd_use);
    // Grant only while stored entries plus outstanding credits leave room for one more flit
    lcrdv_d   = (CW1'(count_d) + CW1'(crd_out_d)) < CW1'(DEPTH);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      crd_out_q <= '0;
      lcrdv_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      crd_out_q <= crd_out_d;
      lcrdv_q   <= lcrdv_d;
    end
  always_ff @(posedge clock)
    if (push) mem_q[wr_ptr_q] <= rxreqflit;
  assign rxreqlcrdv               = lcrdv_q;
  assign pout_valid               = count_q != '0;
  assign rxreq_posq_first_entry_o = mem_q[rd_ptr_q];
  assign posq_count               = count_q;
endmodule

// File: tb/tb_rxreq_posq.sv
// tb_rxreq_posq: scoreboard bench for rxreq_posq with a credit-holding link model
module tb_rxreq_posq;
  localparam int DEPTH = 8;
  localparam int FW    = 32;
  logic clock = 1'b0, reset = 1'b0, rxreqflitv = 1'b0, pout_ready = 1'b0;
  logic rxreqlcrdv, pout_valid, err;
  logic [FW-1:0] rxreqflit = '0, head;
  logic [$clog2(DEPTH):0] posq_count;
  int checks = 0, failures = 0;
  int crd_held = 0;
  bit exp_err = 1'b0;
  logic [FW-1:0] exp_q [$];

  rxreq_posq #(.DEPTH(DEPTH), .FLIT_W(FW), .OPC_LSB(0), .OPC_W(7)) dut (
    .clock(clock), .reset(reset), .rxreqflitv(rxreqflitv), .rxreqflit(rxreqflit),
    .rxreqlcrdv(rxreqlcrdv), .pout_valid(pout_valid), .pout_ready(pout_ready),
    .rxreq_posq_first_entry_o(head), .posq_count(posq_count), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One link cycle; a modelled flit spends a held credit and, if not a credit return, joins the queue
  task automatic step(input logic v, input logic [FW-1:0] f, input logic r, input bit model = 1'b1);
    logic [6:0] opc;
    opc = f[6:0];
    rxreqflitv = v; rxreqflit = f; pout_ready = r;
    if (v && model) crd_held--;
    @(posedge clock);
    if (v && model && opc != 7'd0) exp_q.push_back(f);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r);
  endtask

  task automatic send(input logic [6:0] opc, input logic r, output logic [FW-1:0] f);
    int w;
    w = 0;
    f = $urandom;
    f[6:0] = opc;
    while (crd_held == 0 && w < 50) begin step(1'b0, '0, r); w++; end
    chk("credit_wait", crd_held > 0, 1);
    if (crd_held > 0) step(1'b1, f, r);
  endtask

  function automatic logic [6:0] nop();
    return 7'($urandom_range(1, 127));
  endfunction

  // Monitor: credit accounting, occupancy/head checks, and scoreboard pop on handshake
  always @(negedge clock) if (reset) begin
    if (rxreqlcrdv) crd_held++;
    chk("count", posq_count, exp_q.size());
    chk("valid", pout_valid, exp_q.size() != 0);
    chk("err", err, exp_err);
    chk("invariant", int'(posq_count) + crd_held <= DEPTH, 1);
    if (pout_valid && exp_q.size() != 0) chk("head", head, exp_q[0]);
    if (pout_valid && pout_ready) begin
      if (exp_q.size() == 0) chk("pop_empty", 1, 0);
      else void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f, f0;
    #1;
    chk("rst_lcrdv", rxreqlcrdv, 0);
    chk("rst_valid", pout_valid, 0);
    chk("rst_count", posq_count, 0);
    chk("rst_err", err, 0);
    #21 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("first_crd", rxreqlcrdv, i < DEPTH);
    end
    chk("crd_total", crd_held, DEPTH);
    send(nop(), 1'b0, f0);
    for (int i = 1; i < DEPTH; i++) send(nop(), 1'b0, f);
    idle(2, 1'b0);
    chk("full_count", posq_count, DEPTH);
    chk("full_lcrdv", rxreqlcrdv, 0);
    chk("full_head", head, f0);
`ifdef RXREQ_POSQ_ERR_CHK_EN
    f = $urandom;
    f[6:0] = 7'h11;
    step(1'b1, f, 1'b0, 1'b0);
    chk("err_set", err, 1);
    exp_err = 1'b1;
    idle(3, 1'b0);
    chk("err_sticky", err, 1);
    chk("err_count", posq_count, DEPTH);
`endif
    step(1'b0, '0, 1'b1);
    chk("recycle_crd", rxreqlcrdv, 1);
    chk("pop_count", posq_count, DEPTH - 1);
    idle(14, 1'b1);
    chk("drain_crd", crd_held, DEPTH);
    for (int i = 0; i < 20; i++) begin
      send(nop(), 1'b1, f);
      chk("stream_count", posq_count, 1);
      chk("stream_valid", pout_valid, 1);
    end
    idle(12, 1'b1);
    chk("stream_crd", crd_held, DEPTH);
    send(nop(), 1'b0, f);
    send(7'd0, 1'b0, f);
    send(nop(), 1'b0, f);
    idle(1, 1'b0);
    chk("lcrd_count", posq_count, 2);
    idle(12, 1'b1);
    chk("lcrd_crd", crd_held, DEPTH);
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom % 4) != 0;
      if (crd_held > 0 && ($urandom % 3) != 0) send(($urandom % 5 == 0) ? 7'd0 : nop(), r, f);
      else step(1'b0, '0, r);
    end
    idle(16, 1'b1);
    chk("rand_empty", posq_count, 0);
    chk("rand_crd", crd_held, DEPTH);
    for (int i = 0; i < 5; i++) send(nop(), 1'b0, f);
    idle(1, 1'b0);
    chk("pre_rst_count", posq_count, 5);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", pout_valid, 0);
    chk("mid_rst_count", posq_count, 0);
    chk("mid_rst_lcrdv", rxreqlcrdv, 0);
    chk("mid_rst_err", err, 0);
    exp_q.delete();
    crd_held = 0;
    exp_err = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("restart_crd", rxreqlcrdv, i < DEPTH);
    end
    chk("restart_total", crd_held, DEPTH);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
